// File: rtl/int_xing_pkg.sv
// int_xing_pkg: shared limits and parameter validation for the interrupt crossing
package int_xing_pkg;
  localparam int INT_MAX = 64;
  localparam int SYNC_DEPTH_MIN = 2;
  localparam int SYNC_DEPTH_MAX = 8;
  function automatic bit cfg_ok(input int num_int, input int sync_depth);
    return num_int >= 1 && num_int <= INT_MAX &&
           sync_depth >= SYNC_DEPTH_MIN && sync_depth <= SYNC_DEPTH_MAX;
  endfunction
endpackage

// File: rtl/synchronizer_shift_reg.sv
// synchronizer_shift_reg: multi-flop synchronizer chain with sync reset to 0
module synchronizer_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q
);
  logic [DEPTH-1:0][WIDTH-1:0] s;
  always_ff @(posedge clock)
    s <= reset ? '0 : {s[DEPTH-2:0], io_d};
  assign io_q = s[DEPTH-1];
endmodule

// File: rtl/int_xing_sync.sv
// int_xing_sync: synchronizes async interrupt lines, per-channel level/edge capture, masking and summary
module int_xing_sync
  import int_xing_pkg::*;
#(
  parameter int                 NUM_INT    = 2,
  parameter int                 SYNC_DEPTH = 3,
  parameter logic [NUM_INT-1:0] EDGE_MODE  = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_int_in,
  input  logic [NUM_INT-1:0] io_mask,
  input  logic [NUM_INT-1:0] io_clear,
  output logic [NUM_INT-1:0] auto_int_out,
  output logic [NUM_INT-1:0] io_pending,
  output logic               io_any
);
  if (!cfg_ok(NUM_INT, SYNC_DEPTH)) begin : g_bad_cfg
    $error("int_xing_sync: NUM_INT or SYNC_DEPTH out of range");
  end
  logic [NUM_INT-1:0] q, prev, pend;
  synchronizer_shift_reg #(.WIDTH(NUM_INT), .DEPTH(SYNC_DEPTH)) u_sync (
    .clock(clock),
    .reset(reset),
    .io_d (auto_int_in),
    .io_q (q)
  );
  // a rise sets pend even when a clear arrives on the same edge; level channels keep pend at 0
  always_ff @(posedge clock)
    if (reset) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= q;
      pend <= EDGE_MODE & ((q & ~prev) | (pend & ~io_clear));
    end
  assign io_pending   = (EDGE_MODE & pend) | (~EDGE_MODE & q);
  assign auto_int_out = io_pending & ~io_mask;
  assign io_any       = |auto_int_out;
endmodule

// File: tb/tb_int_xing_sync.sv
// tb_int_xing_sync: history-based reference model plus directed literal checks for int_xing_sync
module tb_int_xing_sync;
  localparam int N = 2;
  localparam int D = 3;
  localparam logic [N-1:0] EM = 2'b10;
  logic clock = 0, reset;
  logic [N-1:0] auto_int_in, io_mask, io_clear, auto_int_out, io_pending;
  logic io_any;
  int checks = 0, failures = 0;
  int n = -1;
  bit       rst_h [0:4095];
  logic [N-1:0] in_h [0:4095];
  logic [N-1:0] pnd_h[0:4095];
  logic [N-1:0] exp_p, exp_o;

  int_xing_sync #(.NUM_INT(N), .SYNC_DEPTH(D), .EDGE_MODE(EM)) dut (
    .clock(clock), .reset(reset), .auto_int_in(auto_int_in), .io_mask(io_mask),
    .io_clear(io_clear), .auto_int_out(auto_int_out), .io_pending(io_pending), .io_any(io_any)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // synchronized value after edge k is the input seen D-1 edges earlier, unless a reset edge intervened
  function automatic logic [N-1:0] q_at(input int k);
    if (k - D + 1 < 0) return '0;
    for (int j = k - D + 1; j <= k; j++) if (rst_h[j]) return '0;
    return in_h[k-D+1];
  endfunction

  function automatic logic [N-1:0] prv(input int k);
    if (k < 0 || rst_h[k]) return '0;
    return q_at(k - 1);
  endfunction

  always @(posedge clock) begin
    n++;
    rst_h[n] = reset;
    in_h[n]  = auto_int_in;
    pnd_h[n] = (n == 0 || reset) ? '0 :
               EM & ((q_at(n-1) & ~prv(n-1)) | (pnd_h[n-1] & ~io_clear));
    #2;
    exp_p = (EM & pnd_h[n]) | (~EM & q_at(n));
    exp_o = exp_p & ~io_mask;
    chk("model_pending", 8'(io_pending), 8'(exp_p));
    chk("model_out", 8'(auto_int_out), 8'(exp_o));
    chk("model_any", 8'(io_any), 8'(|exp_o));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1; auto_int_in = 2'b11; io_mask = '0; io_clear = '0;
    repeat (3) @(negedge clock);
    chk("in_reset", {io_any, io_pending, auto_int_out}, 8'd0);
    reset = 0;
    step(); chk("rel_c0", {io_any, io_pending, auto_int_out}, 8'd0);
    step(); chk("rel_c1", {io_any, io_pending, auto_int_out}, 8'd0);
    step(); chk("rel_lvl_out", 8'(auto_int_out), 8'b01);
    step(); chk("rel_edge_out", 8'(auto_int_out), 8'b11);
    chk("rel_any", 8'(io_any), 8'd1);
    @(negedge clock) io_clear = 2'b10;
    step(); chk("clr_edge", 8'(io_pending), 8'b01);
    @(negedge clock) begin io_clear = 2'b01; auto_int_in = 2'b10; end
    step(); chk("lvl_hold0", 8'(auto_int_out), 8'b01);
    @(negedge clock) io_clear = '0;
    step(); chk("lvl_hold1", 8'(auto_int_out), 8'b01);
    step(); chk("lvl_drop", 8'(auto_int_out), 8'b00);
    @(negedge clock) auto_int_in = 2'b00;
    repeat (4) @(negedge clock);
    auto_int_in = 2'b10;
    step(); step();
    @(negedge clock) auto_int_in = 2'b00;
    step(); chk("edge_early", 8'(io_pending), 8'b00);
    step(); chk("edge_pend", 8'(io_pending), 8'b10);
    repeat (5) step();
    chk("edge_held", 8'(auto_int_out), 8'b10);
    @(negedge clock) io_clear = 2'b10;
    step(); chk("edge_cleared", 8'(io_pending), 8'b00);
    @(negedge clock) begin io_clear = '0; auto_int_in = 2'b10; end
    step(); step();
    @(negedge clock) auto_int_in = 2'b00;
    step(); step(); chk("re_pend", 8'(io_pending), 8'b10);
    @(negedge clock) auto_int_in = 2'b10;
    step(); step();
    @(negedge clock) auto_int_in = 2'b00;
    step();
    @(negedge clock) io_clear = 2'b10;
    step(); chk("set_wins", 8'(io_pending), 8'b10);
    @(negedge clock) io_clear = '0;
    @(negedge clock) io_clear = 2'b10;
    step(); chk("clear_alone", 8'(io_pending), 8'b00);
    @(negedge clock) begin io_clear = '0; io_mask = 2'b10; auto_int_in = 2'b10; end
    step(); step();
    @(negedge clock) auto_int_in = 2'b00;
    step(); step();
    chk("mask_out", 8'(auto_int_out), 8'b00);
    chk("mask_pend", 8'(io_pending), 8'b10);
    chk("mask_any", 8'(io_any), 8'd0);
    @(negedge clock) io_mask = '0;
    #1;
    chk("unmask_out", 8'(auto_int_out), 8'b10);
    chk("unmask_any", 8'(io_any), 8'd1);
    @(negedge clock) auto_int_in = 2'b11;
    step();
    @(negedge clock) reset = 1;
    step(); chk("mid_reset", {io_any, io_pending, auto_int_out}, 8'd0);
    @(negedge clock) reset = 0;
    step(); chk("rr_c0", {io_any, io_pending, auto_int_out}, 8'd0);
    step(); chk("rr_c1", {io_any, io_pending, auto_int_out}, 8'd0);
    step(); chk("rr_lvl", 8'(io_pending), 8'b01);
    step(); chk("rr_edge", 8'(io_pending), 8'b11);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock) begin
        auto_int_in = N'($urandom);
        io_clear    = N'($urandom);
        io_mask     = N'($urandom);
      end
      @(negedge clock) io_clear = '0;
    end
    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
